// File: rtl/dual_fifo_pkg.sv
// Shared definitions for the dual-issue FIFO write-side arbiters.
//   arb_state_e : packet-lock state of an arbiter (idle / locked to one requester)
//   Dual*       : the only legal encodings of a dual-issue valid/ready pair
//   wrap_inc    : modular increment with an explicit wrap, so that
//                 non-power-of-two requester counts wrap correctly
package dual_fifo_pkg;

    typedef enum logic [0:0] {
        ArbIdle   = 1'b0,
        ArbLocked = 1'b1
    } arb_state_e;

    localparam logic [1:0] DualNone = 2'b00;
    localparam logic [1:0] DualOne  = 2'b01;
    localparam logic [1:0] DualTwo  = 2'b11;

    // (base + step) mod n for 0 <= base < n and 0 <= step < n.
    function automatic int wrap_inc(int base, int step, int n);
        int sum;
        sum = base + step;
        if (sum >= n) begin
            sum = sum - n;
        end
        return sum;
    endfunction

endpackage

// File: rtl/dual_issue_rr_pick.sv
// Combinational rotate-priority picker.
// Returns the first requester whose bit is set in req, searching upward from
// ptr with wrap-around. With no request set, idx falls back to ptr.
//   req : one request bit per requester
//   ptr : highest-priority requester this cycle
//   idx : selected requester
//   any : at least one request bit is set
module dual_issue_rr_pick
    import dual_fifo_pkg::*;
#(
    parameter  int NumReq = 2,
    localparam int IdxW   = $clog2(NumReq)
) (
    input  logic [NumReq-1:0] req,
    input  logic [IdxW-1:0]   ptr,
    output logic [IdxW-1:0]   idx,
    output logic              any
);

    // Walk the offsets from farthest to nearest so the nearest hit to ptr is
    // the last assignment and therefore wins.
    always_comb begin
        // NOTE: every output gets a default before the loop; a path that
        // leaves one unassigned would infer a latch.
        idx = ptr;
        any = 1'b0;
        for (int i = NumReq - 1; i >= 0; i--) begin
            if (req[wrap_inc(int'(ptr), i, NumReq)]) begin
                idx = IdxW'(wrap_inc(int'(ptr), i, NumReq));
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dual_fifo_wr_arb.sv
// Round-robin, packet-locking arbiter merging NumReq dual-issue producers into
// one dual-issue write port. No storage, no added latency: data and
// handshakes are steered combinationally; only the lock state and the
// round-robin pointer are registered.
//   clk_i, rst_ni       : clock, asynchronous active-low reset
//   flush_i             : synchronous flush back to idle, pointer to 0
//   req_valid_i/rdy_o   : per-requester dual-issue handshake (00/01/11)
//   req_data0/1_i       : per-requester slot data (slot 0 first)
//   req_last_i          : per-requester end-of-packet flags per slot
//   wr_valid_o/rdy_i    : downstream dual-issue handshake
//   wr_data0/1_o        : granted requester's data
//   wr_last_o           : granted requester's last flags, masked by wr_valid_o
//   grant_o             : current grant index
//   locked_o            : arbiter is locked to a requester mid-packet
module dual_fifo_wr_arb
    import dual_fifo_pkg::*;
#(
    parameter  int NumReq = 2,
    parameter  int Width  = 32,
    localparam int IdxW   = $clog2(NumReq)
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          flush_i,
    input  logic [NumReq-1:0][1:0]        req_valid_i,
    input  logic [NumReq-1:0][Width-1:0]  req_data0_i,
    input  logic [NumReq-1:0][Width-1:0]  req_data1_i,
    input  logic [NumReq-1:0][1:0]        req_last_i,
    output logic [NumReq-1:0][1:0]        req_rdy_o,
    output logic [1:0]                    wr_valid_o,
    output logic [Width-1:0]              wr_data0_o,
    output logic [Width-1:0]              wr_data1_o,
    output logic [1:0]                    wr_last_o,
    input  logic [1:0]                    wr_rdy_i,
    output logic [IdxW-1:0]               grant_o,
    output logic                          locked_o
);

    arb_state_e        state_q;
    logic [IdxW-1:0]   rr_ptr_q;
    logic [IdxW-1:0]   lock_id_q;

    logic [NumReq-1:0] slot0_req;
    logic [IdxW-1:0]   pick_idx;
    logic              pick_any;
    logic [IdxW-1:0]   grant;
    logic              accept1;
    logic              accept2;
    logic              acc_last;

    // Only slot 0 decides eligibility; an illegal 10 therefore never requests.
    always_comb begin
        for (int r = 0; r < NumReq; r++) begin
            slot0_req[r] = req_valid_i[r][0];
        end
    end

    dual_issue_rr_pick #(
        .NumReq (NumReq)
    ) u_pick (
        .req (slot0_req),
        .ptr (rr_ptr_q),
        .idx (pick_idx),
        .any (pick_any)
    );

    // A locked requester keeps the port even while it has nothing to send.
    assign grant    = (state_q == ArbLocked) ? lock_id_q : pick_idx;
    assign grant_o  = grant;
    assign locked_o = (state_q == ArbLocked);

    always_comb begin
        wr_valid_o = req_valid_i[grant];
        if (!wr_valid_o[0]) begin
            wr_valid_o = DualNone;
        end else if (req_last_i[grant][0]) begin
            // A packet ending in slot 0 must not drag the next packet's first
            // beat into the same pair.
            wr_valid_o = DualOne;
        end
        if (flush_i) begin
            wr_valid_o = DualNone;
        end
    end

    assign wr_data0_o = req_data0_i[grant];
    assign wr_data1_o = req_data1_i[grant];
    assign wr_last_o  = req_last_i[grant] & wr_valid_o;

    assign accept2  = (wr_valid_o == DualTwo) && (wr_rdy_i == DualTwo);
    assign accept1  = wr_valid_o[0] & wr_rdy_i[0];
    assign acc_last = accept2 ? req_last_i[grant][1] : req_last_i[grant][0];

    // Ready is rebuilt from the accept terms so it can only ever be 00/01/11.
    always_comb begin
        req_rdy_o        = '0;
        req_rdy_o[grant] = {accept2, accept1};
    end

    // NOTE: the lock/pointer registers take an asynchronous reset and use
    // non-blocking assignments, so every reader in the same edge sees the old
    // values; blocking here would create order-dependent races.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ArbIdle;
            rr_ptr_q  <= '0;
            lock_id_q <= '0;
        end else if (flush_i) begin
            state_q  <= ArbIdle;
            rr_ptr_q <= '0;
        end else if (accept1) begin
            unique case (state_q)
                ArbIdle: begin
                    if (acc_last) begin
                        rr_ptr_q <= IdxW'(wrap_inc(int'(grant), 1, NumReq));
                    end else begin
                        state_q   <= ArbLocked;
                        lock_id_q <= grant;
                    end
                end
                ArbLocked: begin
                    if (acc_last) begin
                        state_q  <= ArbIdle;
                        rr_ptr_q <= IdxW'(wrap_inc(int'(lock_id_q), 1, NumReq));
                    end
                end
                default: state_q <= ArbIdle;
            endcase
        end
    end

`ifdef FORMAL
    logic [NumReq-1:0] rdy_any;

    always_comb begin
        for (int r = 0; r < NumReq; r++) begin
            rdy_any[r] = |req_rdy_o[r];
            assume (req_valid_i[r] != 2'b10);
            assert (req_rdy_o[r] != 2'b10);
        end
        assume (wr_rdy_i != 2'b10);
        assert (wr_valid_o != 2'b10);
        assert ($onehot0(rdy_any));
    end

    always_ff @(posedge clk_i) begin
        if (rst_ni && $past(rst_ni) && locked_o && $past(locked_o)) begin
            assert (grant_o == $past(grant_o));
        end
    end
`endif

endmodule

// File: tb/tb_dual_fifo_wr_arb.sv
// Self-checking bench for dual_fifo_wr_arb: a directed vector table against a
// two-requester instance, plus hand-written sequences for pointer wrap on a
// three-requester instance and asynchronous reset mid-packet.
module tb_dual_fifo_wr_arb;

    localparam int Width = 32;

    logic clk_i = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk_i = ~clk_i;

    // Two-requester instance.
    logic                   flush2;
    logic [1:0][1:0]        valid2, last2, rdy2;
    logic [1:0][Width-1:0]  d0_2, d1_2;
    logic [1:0]             wv2, wl2, wrdy2;
    logic [Width-1:0]       wd0_2, wd1_2;
    logic                   g2, lk2;

    // Three-requester instance.
    logic                   flush3;
    logic [2:0][1:0]        valid3, last3, rdy3;
    logic [2:0][Width-1:0]  d0_3, d1_3;
    logic [1:0]             wv3, wl3, wrdy3;
    logic [Width-1:0]       wd0_3, wd1_3;
    logic [1:0]             g3;
    logic                   lk3;

    dual_fifo_wr_arb #(.NumReq(2), .Width(Width)) dut2 (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush2),
        .req_valid_i(valid2), .req_data0_i(d0_2), .req_data1_i(d1_2),
        .req_last_i(last2), .req_rdy_o(rdy2), .wr_valid_o(wv2),
        .wr_data0_o(wd0_2), .wr_data1_o(wd1_2), .wr_last_o(wl2),
        .wr_rdy_i(wrdy2), .grant_o(g2), .locked_o(lk2)
    );

    dual_fifo_wr_arb #(.NumReq(3), .Width(Width)) dut3 (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush3),
        .req_valid_i(valid3), .req_data0_i(d0_3), .req_data1_i(d1_3),
        .req_last_i(last3), .req_rdy_o(rdy3), .wr_valid_o(wv3),
        .wr_data0_o(wd0_3), .wr_data1_o(wd1_3), .wr_last_o(wl3),
        .wr_rdy_i(wrdy3), .grant_o(g3), .locked_o(lk3)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // v/l/e_rr pack requester 1 in [3:2] and requester 0 in [1:0].
    typedef struct packed {
        logic       fl;
        logic [3:0] v;
        logic [3:0] l;
        logic [1:0] rdy;
        logic [1:0] e_wv;
        logic [3:0] e_rr;
        logic       e_g;
        logic       e_lk;
        logic [1:0] e_wl;
    } vec_t;

    function automatic vec_t mk(logic fl, logic [3:0] v, logic [3:0] l, logic [1:0] rdy,
                                logic [1:0] e_wv, logic [3:0] e_rr, logic e_g,
                                logic e_lk, logic [1:0] e_wl);
        vec_t t;
        t.fl = fl; t.v = v; t.l = l; t.rdy = rdy;
        t.e_wv = e_wv; t.e_rr = e_rr; t.e_g = e_g; t.e_lk = e_lk; t.e_wl = e_wl;
        return t;
    endfunction

    vec_t vecs [24];

    function automatic logic [31:0] dat0(int r, int k);
        return 32'hD000_0000 | (k << 8) | r;
    endfunction

    function automatic logic [31:0] dat1(int r, int k);
        return 32'hE000_0000 | (k << 8) | r;
    endfunction

    initial begin
        // reset state
        vecs[0]  = mk(0, 4'b0000, 4'b0000, 2'b11, 2'b00, 4'b0000, 0, 0, 2'b00);
        // single packet from req0: 2 + 1 beats
        vecs[1]  = mk(0, 4'b0011, 4'b0000, 2'b11, 2'b11, 4'b0011, 0, 0, 2'b00);
        vecs[2]  = mk(0, 4'b0001, 4'b0001, 2'b11, 2'b01, 4'b0001, 0, 1, 2'b01);
        vecs[3]  = mk(0, 4'b0000, 4'b0000, 2'b11, 2'b00, 4'b0000, 1, 0, 2'b00);
        // fairness with one-beat packets; last vector also checks slot-1 masking
        vecs[4]  = mk(0, 4'b0101, 4'b0101, 2'b11, 2'b01, 4'b0100, 1, 0, 2'b01);
        vecs[5]  = mk(0, 4'b0101, 4'b0101, 2'b11, 2'b01, 4'b0001, 0, 0, 2'b01);
        vecs[6]  = mk(0, 4'b0101, 4'b0101, 2'b11, 2'b01, 4'b0100, 1, 0, 2'b01);
        vecs[7]  = mk(0, 4'b1111, 4'b0101, 2'b11, 2'b01, 4'b0001, 0, 0, 2'b01);
        // lock holds through a bubble of the locked requester
        vecs[8]  = mk(0, 4'b0011, 4'b0000, 2'b11, 2'b11, 4'b0011, 0, 0, 2'b00);
        vecs[9]  = mk(0, 4'b1100, 4'b0000, 2'b11, 2'b00, 4'b0000, 0, 1, 2'b00);
        vecs[10] = mk(0, 4'b1100, 4'b0000, 2'b11, 2'b00, 4'b0000, 0, 1, 2'b00);
        vecs[11] = mk(0, 4'b1101, 4'b0001, 2'b11, 2'b01, 4'b0001, 0, 1, 2'b01);
        vecs[12] = mk(0, 4'b1100, 4'b0000, 2'b11, 2'b11, 4'b1100, 1, 0, 2'b00);
        // backpressure split while locked to req1
        vecs[13] = mk(0, 4'b1100, 4'b0000, 2'b01, 2'b11, 4'b0100, 1, 1, 2'b00);
        vecs[14] = mk(0, 4'b1100, 4'b1000, 2'b01, 2'b11, 4'b0100, 1, 1, 2'b10);
        vecs[15] = mk(0, 4'b1100, 4'b1000, 2'b11, 2'b11, 4'b1100, 1, 1, 2'b10);
        vecs[16] = mk(0, 4'b0000, 4'b0000, 2'b11, 2'b00, 4'b0000, 0, 0, 2'b00);
        // split accept of a one-beat packet, then downstream fully stalled
        vecs[17] = mk(0, 4'b0011, 4'b0001, 2'b01, 2'b01, 4'b0001, 0, 0, 2'b01);
        vecs[18] = mk(0, 4'b0011, 4'b0000, 2'b00, 2'b11, 4'b0000, 0, 0, 2'b00);
        vecs[19] = mk(0, 4'b0000, 4'b0000, 2'b11, 2'b00, 4'b0000, 1, 0, 2'b00);
        // flush mid-packet while locked to req1
        vecs[20] = mk(0, 4'b1100, 4'b0000, 2'b11, 2'b11, 4'b1100, 1, 0, 2'b00);
        vecs[21] = mk(1, 4'b1111, 4'b0000, 2'b11, 2'b00, 4'b0000, 1, 1, 2'b00);
        vecs[22] = mk(0, 4'b1111, 4'b0000, 2'b11, 2'b11, 4'b0011, 0, 0, 2'b00);
        vecs[23] = mk(0, 4'b0000, 4'b0000, 2'b11, 2'b00, 4'b0000, 0, 1, 2'b00);

        flush2 = 1'b0; valid2 = '0; last2 = '0; wrdy2 = 2'b11;
        flush3 = 1'b0; valid3 = '0; last3 = '0; wrdy3 = 2'b11;
        for (int r = 0; r < 2; r++) begin d0_2[r] = dat0(r, 0); d1_2[r] = dat1(r, 0); end
        for (int r = 0; r < 3; r++) begin d0_3[r] = dat0(r, 0); d1_3[r] = dat1(r, 0); end

        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;

        // ---------------- table-driven run on the two-requester instance
        for (int k = 0; k < 24; k++) begin
            @(negedge clk_i);
            flush2 = vecs[k].fl;
            valid2 = vecs[k].v;
            last2  = vecs[k].l;
            wrdy2  = vecs[k].rdy;
            for (int r = 0; r < 2; r++) begin d0_2[r] = dat0(r, k); d1_2[r] = dat1(r, k); end
            #1;
            check($sformatf("v%0d wr_valid", k), 32'(wv2), 32'(vecs[k].e_wv));
            check($sformatf("v%0d req_rdy", k), 32'(rdy2), 32'(vecs[k].e_rr));
            check($sformatf("v%0d grant", k), 32'(g2), 32'(vecs[k].e_g));
            check($sformatf("v%0d locked", k), 32'(lk2), 32'(vecs[k].e_lk));
            check($sformatf("v%0d wr_last", k), 32'(wl2), 32'(vecs[k].e_wl));
            if (vecs[k].e_wv[0])
                check($sformatf("v%0d data0", k), wd0_2, dat0(int'(vecs[k].e_g), k));
            if (vecs[k].e_wv[1])
                check($sformatf("v%0d data1", k), wd1_2, dat1(int'(vecs[k].e_g), k));
        end

        // ---------------- asynchronous reset mid-packet (dut2 locked to req0)
        @(negedge clk_i);
        flush2 = 1'b0; valid2 = '0; last2 = '0;
        #2;
        rst_ni = 1'b0;
        #1;
        check("async_rst locked", 32'(lk2), 32'd0);
        check("async_rst grant", 32'(g2), 32'd0);
        check("async_rst wr_valid", 32'(wv2), 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;

        // ---------------- pointer wrap on the three-requester instance
        // req0 then req1 send one-beat packets so rr_ptr reaches 2.
        @(negedge clk_i);
        valid3 = '0; last3 = '0;
        valid3[0] = 2'b01; last3[0] = 2'b01;
        #1;
        check("wrap a grant", 32'(g3), 32'd0);
        check("wrap a rdy", 32'(rdy3), 32'b00_00_01);

        @(negedge clk_i);
        valid3 = '0; last3 = '0;
        valid3[1] = 2'b01; last3[1] = 2'b01;
        #1;
        check("wrap b grant", 32'(g3), 32'd1);
        check("wrap b rdy", 32'(rdy3), 32'b00_01_00);

        // req2 and req0 both valid; pointer at 2 favours req2, which locks.
        @(negedge clk_i);
        valid3 = '0; last3 = '0;
        valid3[2] = 2'b11; valid3[0] = 2'b11;
        #1;
        check("wrap c grant", 32'(g3), 32'd2);
        check("wrap c rdy", 32'(rdy3), 32'b11_00_00);
        check("wrap c data1", wd1_3, dat1(2, 0));

        @(negedge clk_i);
        valid3[2] = 2'b01; last3[2] = 2'b01;
        #1;
        check("wrap d locked", 32'(lk3), 32'd1);
        check("wrap d grant", 32'(g3), 32'd2);
        check("wrap d wr_valid", 32'(wv3), 32'b01);

        // Pointer wrapped 2 -> 0: req0 wins over req2.
        @(negedge clk_i);
        valid3 = '0; last3 = '0;
        valid3[2] = 2'b11; valid3[0] = 2'b11;
        wrdy3 = 2'b00;
        #1;
        check("wrap e locked", 32'(lk3), 32'd0);
        check("wrap e grant", 32'(g3), 32'd0);
        check("wrap e rdy", 32'(rdy3), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/dual_fifo_wr_arb.md
# dual_fifo_wr_arb

Round-robin, packet-locking arbiter that merges NumReq dual-issue producer streams into one dual-issue write port, normally a dual-issue FIFO input. Grants are held per packet: once a requester is granted, it keeps the port until a beat marked `last` is accepted. The arbiter adds no storage and no latency. It only steers handshakes and data, and maintains the round-robin pointer and lock state.

## Interface
Parameters:
- NumReq, 2: number of requesters; legal range 2..4.
- Width, 32: data width per slot.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- flush_i  in  1  synchronous flush; returns arbiter to idle.
- req_valid_i  in  [NumReq-1:0][1:0]  per-requester valid; legal encodings 00/01/11.
- req_data0_i, req_data1_i  in  [NumReq-1:0][Width-1:0]  slot-0 and slot-1 data (slot 0 is first in sequence).
- req_last_i  in  [NumReq-1:0][1:0]  end-of-packet flag per slot.
- req_rdy_o  out  [NumReq-1:0][1:0]  per-requester ready; driven only with 00/01/11.
- wr_valid_o  out  2  output valid; driven only with 00/01/11.
- wr_data0_o, wr_data1_o  out  Width  granted requester's data.
- wr_last_o  out  2  granted requester's last flags, masked by wr_valid_o.
- wr_rdy_i  in  2  downstream ready; legal encodings 00/01/11.
- grant_o  out  $clog2(NumReq)  current grant index; valid when wr_valid_o[0]=1.
- locked_o  out  1  arbiter is in ArbLocked.

## Operation
- States:
  - ArbIdle: grant g = the first requester with req_valid_i[g][0]=1, searching from rr_ptr_q upward with wrap.
  - ArbLocked: g = lock_id_q, regardless of that requester's valid, so a locked requester with valid 00 produces a bubble.
- Slot-1 masking: if req_last_i[g][0]=1, slot 1 is suppressed and wr_valid_o = 01. Packets never share a beat pair.
- Output valid: wr_valid_o = (masked) req_valid_i[g].
- Ready: req_rdy_o[g] = wr_rdy_i & wr_valid_o. All other requesters' ready is 00.
- Accept count n:
  - 2 if wr_valid_o=11 and wr_rdy_i=11.
  - else 1 if wr_valid_o[0] & wr_rdy_i[0].
  - else 0.
- Accepted last: n=1 uses last[0]; n=2 uses last[1].
- Transitions (all only when n>0):
  - ArbIdle, last accepted: stay in ArbIdle; rr_ptr_q <= g+1 mod NumReq.
  - ArbIdle, no last accepted: go to ArbLocked; lock_id_q <= g.
  - ArbLocked, last accepted: go to ArbIdle; rr_ptr_q <= lock_id_q+1 mod NumReq.
  - n=0: no state change.
- Idle with no requester valid: wr_valid_o = 00, all req_rdy_o = 00, grant_o = rr_ptr_q.
- flush_i=1 (same cycle):
  - wr_valid_o and all req_rdy_o forced to 00; no transfer occurs.
  - Next cycle: ArbIdle, rr_ptr_q = 0.
- Illegal requester encoding 10 is treated as 00. A formal assumption covers it; no recovery logic.

## Timing
- Fully combinational from req_* and wr_rdy_i to outputs: zero added latency, no bubble on back-to-back packets.
- State (state_q, rr_ptr_q, lock_id_q) updates on the posedge after the accepting cycle.
- Reset values: ArbIdle, rr_ptr_q=0, lock_id_q=0, locked_o=0. With all requesters idle: wr_valid_o=00 and req_rdy_o all 00.
- Reset asserted mid-packet: lock is dropped immediately (asynchronous). The partial packet is the producer's responsibility.
- Pointer wrap: rr_ptr_q = NumReq-1 with last accepted → 0. For non-power-of-2 NumReq, wrap is explicit, not modular truncation.
- Downstream wr_rdy_i=01 against wr_valid_o=11: only slot 0 transfers; slot 1 is re-presented as slot 0 by the producer next cycle.

## Structure
- Shared package dual_fifo_pkg:
  - typedef arb_state_e {ArbIdle, ArbLocked}.
  - Legal-encoding constants DualNone=2'b00, DualOne=2'b01, DualTwo=2'b11.
- One sub-module, dual_issue_rr_pick: combinational rotate-priority picker (request vector + pointer → index + any-valid). It is reused by other arbiters.
- Formal properties in the `FORMAL` section:
  - Output encodings are legal.
  - At most one requester has nonzero req_rdy_o.
  - While locked_o=1, grant_o is stable.

## Test plan
- Single packet, NumReq=2: req0 valid=11 with last=00, then valid=01 with last=01; wr_rdy_i=11 → 3 beats forwarded, locked_o=1 after cycle 1, idle after cycle 2, rr_ptr=1.
- Fairness: req0 and req1 both send 1-beat packets (last[0]=1) continuously → grant_o alternates 0,1,0,1; each beat has wr_valid_o=01.
- Lock holds through a bubble: req0 locked with valid=00 for 2 cycles while req1 valid=11 → wr_valid_o=00 and req1 rdy=00 for those cycles; req1 granted only after req0's last beat.
- Backpressure split: wr_valid_o=11, wr_rdy_i=01 → req_rdy_o[g]=01, exactly one beat accepted, no state change unless last[0]=1.
- Wrap with NumReq=3: rr_ptr=2; req2 and req0 valid; req2 completes a packet → next grant is 0, rr_ptr=0.
- Flush mid-packet: locked to req1 and flush_i=1 with valid=11 → all rdy=00 that cycle, next cycle ArbIdle, rr_ptr=0, req0 granted first.
